axicb_round_robin_arbiter: RTL and testbench
============================================

Name: axicb_round_robin_arbiter

Overview:
Parametrised, prioritised round-robin arbiter with registered grant and grant locking, for the crossbar switch address and data-path arbitration. It generalises the fixed 4/8-requester round-robin core to any REQ_NB and adds per-requester runtime priority levels, each level with its own independent rotation mask. A granted requester keeps the grant until the downstream transfer signals completion, so a burst is never split. Instantiated once per slave-side switch, between the requesters' valid signals and the channel mux select.

Parameters:
REQ_NB, 4, number of requesters; legal range 2..32.
PRIO_NB, 4, number of priority levels; legal range 1..8; level PRIO_NB-1 is the highest.
PRIO_W, $clog2(PRIO_NB) with a minimum of 1, derived; width of each priority field; never overridden.
ID_W, $clog2(REQ_NB), derived; width of grant_id.

Ports:
aclk  in  1  clock; all logic is rising-edge.
areset  in  1  asynchronous reset, active-high. Assertion clears state immediately; deassertion is synchronised externally.
srst  in  1  synchronous reset, active-high; same effect as areset, applied on the clock edge.
en  in  1  arbitration enable; sampled in IDLE only.
req  in  REQ_NB  request vector, one bit per requester.
prio  in  REQ_NB*PRIO_W  priority per requester; field i is bits [i*PRIO_W +: PRIO_W]; values at or above PRIO_NB are treated as PRIO_NB-1.
done  in  1  completion of the locked transfer (valid & ready & last), sampled in BUSY only.
grant  out  REQ_NB  registered one-hot grant; zero when no grant.
grant_valid  out  1  high while a grant is held; equals |grant.
grant_id  out  ID_W  binary index of the granted requester; 0 when grant_valid is low.

Behaviour:
- Reset (areset or srst):
  - state = IDLE; grant = 0; grant_valid = 0; grant_id = 0.
  - Every per-level mask is set to all-ones.
  - areset clears the outputs asynchronously, including in the middle of BUSY.
- State storage: a 2-state FSM (IDLE, BUSY) plus PRIO_NB masks, each REQ_NB bits wide.
- Winner selection (combinational, used in IDLE):
  - L = highest priority level among requesters with req set.
  - cand = req restricted to requesters whose priority is L.
  - masked = cand & mask[L].
  - If masked is non-zero, the winner is the lowest set index of masked; otherwise the winner is the lowest set index of cand.
- IDLE:
  - If en and req is non-zero: register the winner into grant and grant_id, set grant_valid = 1, and go to BUSY.
  - mask[L] updates on the same edge: if the winner index is w < REQ_NB-1, bits above w are 1 and the rest are 0; if w = REQ_NB-1, the mask becomes all-ones.
  - Masks of all other levels are unchanged.
  - Otherwise remain in IDLE with all outputs at 0.
- Latency: a req sampled in IDLE produces grant on the next cycle.
- BUSY:
  - grant, grant_id and grant_valid are held constant.
  - Changes on req, prio and en are ignored. The granted requester dropping its req does not release the grant.
  - done = 1: on that edge clear grant, grant_valid and grant_id, and go to IDLE.
  - Minimum gap between grants is therefore one IDLE cycle: done at cycle t, IDLE at t+1, new grant visible at t+2.
- Simultaneous events:
  - srst together with done: the reset wins.
  - done asserted in IDLE: ignored.
- Priority: a higher level with any active request always wins. Lower-level masks do not advance while they lose, so lower levels starve for as long as a higher level keeps requesting; this is by design.
- With PRIO_NB = 1 the block behaves as a plain round-robin arbiter with a registered, locked grant.
- Invariants (for assertions):
  - grant is always one-hot or zero.
  - grant_valid == |grant.
  - grant_id matches the index of the grant bit.

Test Plan:
1. Reset: assert areset in the middle of BUSY (REQ_NB=4, grant=0100) -> grant=0000, grant_valid=0, grant_id=0 with no clock edge; after release, req=1111 with en=1 -> grant=0001.
2. Rotation, all requesters at priority 0, req=1111, en=1, done pulsed one cycle after each grant -> grant sequence 0001, 0010, 0100, 1000, 0001; grant_id sequence 0, 1, 2, 3, 0; each grant appears 2 cycles after the previous done.
3. Sparse and lonely requests: req=1101 -> grants 0001, 0100, 1000, 0001. Then req=0011 -> 0001, 0010, 0001 (falls back to the unmasked set after the mask becomes 1100).
4. Priority: prio[2]=1, others 0, req=1111 -> 0100 is repeated while req[2]=1. Then req=1011 -> 0001, 0010, 1000, showing the level-0 mask resumed where it left off and was not disturbed by the level-1 grants.
5. Lock: grant=0010, then drop req[1] and raise req[0], toggle prio, hold done=0 for 10 cycles -> grant stays 0010 throughout; done=1 -> grant=0000 on the next cycle.
6. Enable and srst: en=0 with req=1111 -> no grant. Assert srst together with done in BUSY -> IDLE, grant=0000, all masks reset, so the next grant is 0001.

Source files
------------

// File: rtl/axicb_round_robin_arbiter.sv
// Prioritised round-robin arbiter with a registered, locked grant.
// Each priority level keeps its own rotation mask, so a level that loses to a
// higher one picks up its rotation exactly where it left off.
module axicb_round_robin_arbiter #(
  parameter int REQ_NB  = 4,
  parameter int PRIO_NB = 4,
  parameter int PRIO_W  = (PRIO_NB > 1) ? $clog2(PRIO_NB) : 1,
  parameter int ID_W    = $clog2(REQ_NB)
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     srst,
  input  logic                     en,
  input  logic [REQ_NB-1:0]        req,
  input  logic [REQ_NB*PRIO_W-1:0] prio,
  input  logic                     done,
  output logic [REQ_NB-1:0]        grant,
  output logic                     grant_valid,
  output logic [ID_W-1:0]          grant_id
);

  localparam logic [PRIO_W:0]   PRIO_LIM = (PRIO_W+1)'(PRIO_NB);
  localparam logic [PRIO_W-1:0] PRIO_TOP = PRIO_W'(PRIO_NB - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic [REQ_NB-1:0] mask [PRIO_NB];

  logic [PRIO_W-1:0] eff_prio [REQ_NB];
  logic [PRIO_W-1:0] top_lvl;
  logic [REQ_NB-1:0] cand;
  logic [REQ_NB-1:0] masked;
  logic [REQ_NB-1:0] pick;
  logic [REQ_NB-1:0] win_oh;
  logic [ID_W-1:0]   win_id;
  logic              win_found;
  logic [REQ_NB-1:0] next_mask;

  // Clamp out-of-range priority fields to the highest legal level
  always_comb begin
    for (int i = 0; i < REQ_NB; i++) begin
      eff_prio[i] = prio[i*PRIO_W +: PRIO_W];
      if ({1'b0, eff_prio[i]} >= PRIO_LIM) eff_prio[i] = PRIO_TOP;
    end
  end

  // Highest level among active requesters, and the requesters sitting at it
  always_comb begin
    top_lvl = '0;
    for (int i = 0; i < REQ_NB; i++) begin
      if (req[i] && (eff_prio[i] > top_lvl)) top_lvl = eff_prio[i];
    end
    cand = '0;
    for (int i = 0; i < REQ_NB; i++) begin
      cand[i] = req[i] && (eff_prio[i] == top_lvl);
    end
    masked = cand & mask[top_lvl];
    pick   = (|masked) ? masked : cand;
  end

  // Lowest set index of the chosen set wins, as both one-hot and binary
  always_comb begin
    win_found = 1'b0;
    win_oh    = '0;
    win_id    = '0;
    for (int i = 0; i < REQ_NB; i++) begin
      if (pick[i] && !win_found) begin
        win_found = 1'b1;
        win_oh[i] = 1'b1;
        win_id    = ID_W'(i);
      end
    end
  end

  // Rotation mask for the winning level: everything above the winner, or
  // all-ones once the winner is the top index so the rotation wraps
  always_comb begin
    next_mask = '0;
    for (int i = 0; i < REQ_NB; i++) begin
      next_mask[i] = (i > int'(win_id));
    end
    if (int'(win_id) == REQ_NB - 1) next_mask = '1;
  end

  // Grant FSM: pick a winner in IDLE, hold it untouched until done in BUSY
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      for (int l = 0; l < PRIO_NB; l++) mask[l] <= '1;
    end else if (srst) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      for (int l = 0; l < PRIO_NB; l++) mask[l] <= '1;
    end else begin
      case (state)
        IDLE: begin
          if (en && (|req)) begin
            grant         <= win_oh;
            grant_id      <= win_id;
            grant_valid   <= 1'b1;
            mask[top_lvl] <= next_mask;
            state         <= BUSY;
          end
        end
        BUSY: begin
          if (done) begin
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axicb_round_robin_arbiter.sv
// Directed testbench for axicb_round_robin_arbiter (REQ_NB=4, PRIO_NB=4).
module tb_axicb_round_robin_arbiter;

  logic       aclk;
  logic       areset;
  logic       srst;
  logic       en;
  logic [3:0] req;
  logic [7:0] prio;
  logic       done;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      nm;
    logic [3:0] req;
    logic [7:0] prio;
    logic       en;
    logic       done;
    logic       srst;
    logic [3:0] exp_grant;
    logic [1:0] exp_id;
  } vec_t;

  vec_t vecs[$];

  axicb_round_robin_arbiter #(
    .REQ_NB (4),
    .PRIO_NB(4)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .srst       (srst),
    .en         (en),
    .req        (req),
    .prio       (prio),
    .done       (done),
    .grant      (grant),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic addVec(input string nm, input logic [3:0] r, input logic [7:0] p,
                        input logic e, input logic d, input logic s,
                        input logic [3:0] eg, input logic [1:0] eid);
    vec_t v;
    v.nm = nm; v.req = r; v.prio = p; v.en = e; v.done = d; v.srst = s;
    v.exp_grant = eg; v.exp_id = eid;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [7:0] p,
                               input logic e, input logic d, input logic s);
    req  = r;
    prio = p;
    en   = e;
    done = d;
    srst = s;
  endtask

  task automatic stepCycle();
    @(posedge aclk);
    #1;
  endtask

  task automatic checkOutput(input string nm, input logic [3:0] eg, input logic [1:0] eid);
    total++;
    if (grant !== eg) begin
      bad++;
      $display("[TB] FAIL %s grant: got %b want %b", nm, grant, eg);
    end
    total++;
    if (grant_id !== eid) begin
      bad++;
      $display("[TB] FAIL %s grant_id: got %0d want %0d", nm, grant_id, eid);
    end
    total++;
    if (grant_valid !== (|eg)) begin
      bad++;
      $display("[TB] FAIL %s grant_valid: got %b want %b", nm, grant_valid, |eg);
    end
  endtask

  initial begin
    // Cycle-by-cycle vectors: inputs held for one edge, outputs checked after it
    addVec("srst_with_done", 4'b1111, 8'h00, 1, 1, 1, 4'b0000, 2'd0);
    addVec("rot_g0",  4'b1111, 8'h00, 1, 0, 0, 4'b0001, 2'd0);
    addVec("rot_d0",  4'b1111, 8'h00, 1, 1, 0, 4'b0000, 2'd0);
    addVec("rot_g1",  4'b1111, 8'h00, 1, 0, 0, 4'b0010, 2'd1);
    addVec("rot_d1",  4'b1111, 8'h00, 1, 1, 0, 4'b0000, 2'd0);
    addVec("rot_g2",  4'b1111, 8'h00, 1, 0, 0, 4'b0100, 2'd2);
    addVec("rot_d2",  4'b1111, 8'h00, 1, 1, 0, 4'b0000, 2'd0);
    addVec("rot_g3",  4'b1111, 8'h00, 1, 0, 0, 4'b1000, 2'd3);
    addVec("rot_d3",  4'b1111, 8'h00, 1, 1, 0, 4'b0000, 2'd0);
    addVec("rot_wrap",4'b1111, 8'h00, 1, 0, 0, 4'b0001, 2'd0);
    addVec("rot_d4",  4'b1111, 8'h00, 1, 1, 0, 4'b0000, 2'd0);
    addVec("sp_srst", 4'b0000, 8'h00, 1, 0, 1, 4'b0000, 2'd0);
    addVec("sp_g0",   4'b1101, 8'h00, 1, 0, 0, 4'b0001, 2'd0);
    addVec("sp_d0",   4'b1101, 8'h00, 1, 1, 0, 4'b0000, 2'd0);
    addVec("sp_g2",   4'b1101, 8'h00, 1, 0, 0, 4'b0100, 2'd2);
    addVec("sp_d2",   4'b1101, 8'h00, 1, 1, 0, 4'b0000, 2'd0);
    addVec("sp_g3",   4'b1101, 8'h00, 1, 0, 0, 4'b1000, 2'd3);
    addVec("sp_d3",   4'b1101, 8'h00, 1, 1, 0, 4'b0000, 2'd0);
    addVec("sp_wrap", 4'b1101, 8'h00, 1, 0, 0, 4'b0001, 2'd0);
    addVec("sp_d4",   4'b1101, 8'h00, 1, 1, 0, 4'b0000, 2'd0);
    addVec("lo_srst", 4'b0000, 8'h00, 1, 0, 1, 4'b0000, 2'd0);
    addVec("lo_g0",   4'b0011, 8'h00, 1, 0, 0, 4'b0001, 2'd0);
    addVec("lo_d0",   4'b0011, 8'h00, 1, 1, 0, 4'b0000, 2'd0);
    addVec("lo_g1",   4'b0011, 8'h00, 1, 0, 0, 4'b0010, 2'd1);
    addVec("lo_d1",   4'b0011, 8'h00, 1, 1, 0, 4'b0000, 2'd0);
    addVec("lo_fallb",4'b0011, 8'h00, 1, 0, 0, 4'b0001, 2'd0);
    addVec("lo_d2",   4'b0011, 8'h00, 1, 1, 0, 4'b0000, 2'd0);
    addVec("pr_srst", 4'b0000, 8'h00, 1, 0, 1, 4'b0000, 2'd0);
    addVec("pr_l0g0", 4'b1111, 8'h00, 1, 0, 0, 4'b0001, 2'd0);
    addVec("pr_l0d0", 4'b1111, 8'h00, 1, 1, 0, 4'b0000, 2'd0);
    addVec("pr_hi_a", 4'b1111, 8'h10, 1, 0, 0, 4'b0100, 2'd2);
    addVec("pr_d_a",  4'b1111, 8'h10, 1, 1, 0, 4'b0000, 2'd0);
    addVec("pr_hi_b", 4'b1111, 8'h10, 1, 0, 0, 4'b0100, 2'd2);
    addVec("pr_d_b",  4'b1111, 8'h10, 1, 1, 0, 4'b0000, 2'd0);
    addVec("pr_hi_c", 4'b1111, 8'h10, 1, 0, 0, 4'b0100, 2'd2);
    addVec("pr_d_c",  4'b1111, 8'h10, 1, 1, 0, 4'b0000, 2'd0);
    addVec("pr_res1", 4'b1011, 8'h10, 1, 0, 0, 4'b0010, 2'd1);
    addVec("pr_rd1",  4'b1011, 8'h10, 1, 1, 0, 4'b0000, 2'd0);
    addVec("pr_res3", 4'b1011, 8'h10, 1, 0, 0, 4'b1000, 2'd3);
    addVec("pr_rd3",  4'b1011, 8'h10, 1, 1, 0, 4'b0000, 2'd0);
    addVec("pr_res0", 4'b1011, 8'h10, 1, 0, 0, 4'b0001, 2'd0);
    addVec("pr_rd0",  4'b1011, 8'h10, 1, 1, 0, 4'b0000, 2'd0);
    addVec("en_off",  4'b1111, 8'h00, 0, 0, 0, 4'b0000, 2'd0);
    addVec("idle_done",4'b1111,8'h00, 0, 1, 0, 4'b0000, 2'd0);
    addVec("lvl3_win",4'b1111, 8'h8C, 1, 0, 0, 4'b0010, 2'd1);
    addVec("lvl3_d",  4'b1111, 8'h8C, 1, 1, 0, 4'b0000, 2'd0);

    areset = 1'b1;
    applyStimulus(4'b0000, 8'h00, 0, 0, 0);
    #2;
    checkOutput("reset_state", 4'b0000, 2'd0);
    stepCycle();
    stepCycle();
    areset = 1'b0;

    // Asynchronous reset in the middle of a held grant, then masks are fresh
    applyStimulus(4'b0100, 8'h00, 1, 0, 0);
    stepCycle();
    checkOutput("ar_pre_grant", 4'b0100, 2'd2);
    applyStimulus(4'b0000, 8'h00, 0, 0, 0);
    #2;
    areset = 1'b1;
    #1;
    checkOutput("ar_async_clear", 4'b0000, 2'd0);
    areset = 1'b0;
    applyStimulus(4'b1111, 8'h00, 1, 0, 0);
    stepCycle();
    checkOutput("ar_after_release", 4'b0001, 2'd0);

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].req, vecs[k].prio, vecs[k].en, vecs[k].done, vecs[k].srst);
      stepCycle();
      checkOutput(vecs[k].nm, vecs[k].exp_grant, vecs[k].exp_id);
    end

    // Lock: level-0 mask is 1110 here, so req=0010 wins; then everything churns
    applyStimulus(4'b0010, 8'h00, 1, 0, 0);
    stepCycle();
    checkOutput("lock_grant", 4'b0010, 2'd1);
    for (int c = 0; c < 10; c++) begin
      applyStimulus(4'b0001, (c % 2 == 0) ? 8'hFF : 8'h00, (c % 3) != 0, 0, 0);
      stepCycle();
      checkOutput($sformatf("lock_hold%0d", c), 4'b0010, 2'd1);
    end
    applyStimulus(4'b0001, 8'h00, 1, 1, 0);
    stepCycle();
    checkOutput("lock_release", 4'b0000, 2'd0);

    // srst together with done in BUSY clears every mask (mask0 was 1100)
    applyStimulus(4'b1111, 8'h00, 1, 0, 0);
    stepCycle();
    checkOutput("sr_pre_grant", 4'b0100, 2'd2);
    applyStimulus(4'b1111, 8'h00, 1, 1, 1);
    stepCycle();
    checkOutput("sr_clear", 4'b0000, 2'd0);
    applyStimulus(4'b1111, 8'h00, 1, 0, 0);
    stepCycle();
    checkOutput("sr_fresh_mask", 4'b0001, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
